gpio_input_poll_ctrl: RTL and testbench

Polling sequencer for the 6-bit GPIO input bank PIO, which has no read strobe, no edge capture and no IRQ.
- Periodically drives the PIO's address port and samples its registered readdata.
- Debounces each bit and latches edges into an edge-capture register.
- Exposes state, mask and edges to the HPS through a small Avalon-MM slave with a level IRQ.
- Sits between the PIO and the lightweight HPS bridge in the traffic-light button/sensor path.

---
 rtl/gpio_poll_pkg.sv | 18 +
 rtl/gpio_debounce_bit.sv | 59 +++++
 rtl/gpio_input_poll_ctrl.sv | 133 +++++++++++++
 tb/tb_gpio_input_poll_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_poll_pkg.sv
// Shared definitions for the GPIO input polling controller.
//   - CSR word addresses for the HPS-facing Avalon-MM slave
//   - Poll sequencer state encoding
package gpio_poll_pkg;

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_RSVD  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    SAMPLE,
    UPDATE
  } poll_state_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One-bit debouncer for the GPIO poll controller.
// A new level is accepted after DEBOUNCE_SAMPLES consecutive polled samples
// that differ from the current stable level; any matching sample restarts
// the count.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   update_en     - one-cycle strobe: evaluate the current sample
//   sample        - polled input level
//   stable        - debounced level
//   edge_set      - combinational pulse in the update cycle that accepts
//                   a new level (rising or falling)
module gpio_debounce_bit #(
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic update_en,
  input  logic sample,
  output logic stable,
  output logic edge_set
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    edge_set = 1'b0;
    if (update_en) begin
      if (sample == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sample;
        cnt_d    = '0;
        edge_set = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/gpio_input_poll_ctrl.sv
// Polling sequencer for a GPIO input PIO that has no read strobe, edge
// capture or IRQ. Every POLL_DIV cycles it addresses the PIO, samples its
// registered readdata, debounces each bit and latches accepted transitions
// into an edge-capture register exposed to the HPS.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   pio_address    - PIO address, always 0 (data register)
//   pio_readdata   - PIO readdata, valid one cycle after address
//   s_address      - CSR word address (0 state, 1 rsvd, 2 mask, 3 edges)
//   s_read/s_write - CSR strobes
//   s_writedata    - CSR write data
//   s_readdata     - CSR read data, registered one cycle after s_read
//   irq            - level interrupt, |(edge_capture & irq_mask)
module gpio_input_poll_ctrl
  import gpio_poll_pkg::*;
#(
  parameter int unsigned WIDTH            = 6,
  parameter int unsigned POLL_DIV         = 50000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int unsigned       PCNT_W    = $clog2(POLL_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(POLL_DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

  poll_state_e       state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]  sample_q, sample_d;
  logic [WIDTH-1:0]  irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]  edge_capture_q, edge_capture_d;
  logic [31:0]       s_readdata_q, s_readdata_d;

  logic [WIDTH-1:0]  stable;
  logic [WIDTH-1:0]  edge_set;
  logic [WIDTH-1:0]  edge_clear;
  logic              update_en;
  logic              unused_bits;

  // Only the low WIDTH bits of the PIO data and CSR write data matter.
  assign unused_bits = ^{pio_readdata, s_writedata};

  assign pio_address = '0;
  assign update_en   = (state_q == UPDATE);

  // Poll sequencer: the divider free-runs so the poll period is exactly
  // POLL_DIV cycles regardless of the ADDR/SAMPLE/UPDATE walk.
  always_comb begin
    pcnt_d   = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_ONE;
    state_d  = state_q;
    sample_d = sample_q;
    unique case (state_q)
      IDLE:    if (pcnt_q == PCNT_LAST) state_d = ADDR;
      ADDR:    state_d = SAMPLE;
      SAMPLE: begin
        sample_d = pio_readdata[WIDTH-1:0];
        state_d  = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .update_en(update_en),
      .sample   (sample_q[i]),
      .stable   (stable[i]),
      .edge_set (edge_set[i])
    );
  end

  // CSR access. Reads capture pre-write register values, so a read and a
  // clear of the edge register in one cycle return the bits being cleared.
  always_comb begin
    irq_mask_d   = irq_mask_q;
    edge_clear   = '0;
    s_readdata_d = s_readdata_q;
    if (s_write) begin
      unique case (s_address)
        ADDR_MASK: irq_mask_d = s_writedata[WIDTH-1:0];
        ADDR_EDGE: edge_clear = s_writedata[WIDTH-1:0];
        default:   ;
      endcase
    end
    // A newly accepted edge wins over a same-cycle clear of that bit.
    edge_capture_d = (edge_capture_q & ~edge_clear) | edge_set;
    if (s_read) begin
      unique case (s_address)
        ADDR_STATE: s_readdata_d = 32'(stable);
        ADDR_MASK:  s_readdata_d = 32'(irq_mask_q);
        ADDR_EDGE:  s_readdata_d = 32'(edge_capture_q);
        default:    s_readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pcnt_q         <= '0;
      sample_q       <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      s_readdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      sample_q       <= sample_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      s_readdata_q   <= s_readdata_d;
    end
  end

  assign s_readdata = s_readdata_q;
  assign irq        = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_gpio_input_poll_ctrl.sv
// Directed bench for gpio_input_poll_ctrl (WIDTH=6, POLL_DIV=4,
// DEBOUNCE_SAMPLES=3). CSR read expectations go through a scoreboard queue.
module tb_gpio_input_poll_ctrl;
  import gpio_poll_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;

  logic [5:0]  pio;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          fails  = 0;

  // Upper PIO bits carry junk that must never reach the CSRs.
  assign pio_readdata = {26'h2AAAAAA, pio};

  always #5 clk = ~clk;

  gpio_input_poll_ctrl #(
    .WIDTH(6),
    .POLL_DIV(4),
    .DEBOUNCE_SAMPLES(3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pio_address (pio_address),
    .pio_readdata(pio_readdata),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .s_readdata  (s_readdata),
    .irq         (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    s_address = addr;
    s_read    = 1'b1;
    @(posedge clk);
    #1;
    s_read = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, s_readdata, e);
  endtask

  task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
    s_address   = addr;
    s_writedata = data;
    s_write     = 1'b1;
    @(posedge clk);
    #1;
    s_write = 1'b0;
  endtask

  task automatic csr_rw(input logic [1:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    s_address   = addr;
    s_writedata = data;
    s_read      = 1'b1;
    s_write     = 1'b1;
    @(posedge clk);
    #1;
    s_read  = 1'b0;
    s_write = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, s_readdata, e);
  endtask

  // Advance to the next cycle in which the sequencer is in state st.
  task automatic wait_state(input poll_state_e st, input string tag);
    int unsigned n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (dut.state_q !== st && n < 32);
    check(tag, 32'(dut.state_q), 32'(st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    pio         = 6'h3F;
    s_address   = '0;
    s_read      = 1'b0;
    s_write     = 1'b0;
    s_writedata = '0;

    // Reset with all inputs high.
    idle(3);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", s_readdata, 32'd0);
    check("rst_pio_addr", 32'(pio_address), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    csr_read(ADDR_STATE, 32'h00, "post_rst_state");
    check("post_rst_irq", 32'(irq), 32'd0);
    idle(10);
    csr_read(ADDR_STATE, 32'h00, "state_two_polls");
    idle(3);
    csr_read(ADDR_STATE, 32'h3F, "state_three_polls");
    csr_read(ADDR_EDGE, 32'h3F, "edge_after_rise");
    check("irq_unmasked_rise", 32'(irq), 32'd0);
    csr_write(ADDR_EDGE, 32'h3F);
    csr_read(ADDR_EDGE, 32'h00, "edge_cleared_all");

    // All inputs fall: falling edges are captured too.
    pio = 6'h00;
    idle(14);
    csr_read(ADDR_STATE, 32'h00, "state_all_low");
    csr_read(ADDR_EDGE, 32'h3F, "edge_after_fall");
    csr_write(ADDR_EDGE, 32'h3F);
    csr_read(ADDR_EDGE, 32'h00, "edge_cleared_fall");

    // Glitch: bit 2 high for exactly two polls.
    wait_state(UPDATE, "sync_glitch");
    pio = 6'h04;
    wait_state(UPDATE, "glitch_poll1");
    wait_state(UPDATE, "glitch_poll2");
    pio = 6'h00;
    wait_state(UPDATE, "glitch_low1");
    wait_state(UPDATE, "glitch_low2");
    wait_state(UPDATE, "glitch_low3");
    idle(1);
    csr_read(ADDR_STATE, 32'h00, "glitch_state");
    csr_read(ADDR_EDGE, 32'h00, "glitch_edge");

    // Edge + IRQ on bit 2.
    csr_write(ADDR_MASK, 32'hFFFF_FF04);
    csr_read(ADDR_MASK, 32'h04, "mask_readback");
    wait_state(UPDATE, "sync_edge");
    pio = 6'h04;
    wait_state(UPDATE, "edge_poll1");
    wait_state(UPDATE, "edge_poll2");
    wait_state(UPDATE, "edge_poll3");
    check("irq_before_accept", 32'(irq), 32'd0);
    idle(1);
    check("irq_after_accept", 32'(irq), 32'd1);
    csr_read(ADDR_STATE, 32'h04, "edge_state");
    csr_read(ADDR_EDGE, 32'h04, "edge_capture");
    csr_write(ADDR_EDGE, 32'h04);
    check("irq_after_clear", 32'(irq), 32'd0);
    csr_read(ADDR_EDGE, 32'h00, "edge_after_clear");

    // Masked edge on bit 0: rise then fall.
    csr_write(ADDR_MASK, 32'h00);
    wait_state(UPDATE, "sync_masked");
    pio = 6'h05;
    wait_state(UPDATE, "masked_hi1");
    wait_state(UPDATE, "masked_hi2");
    wait_state(UPDATE, "masked_hi3");
    idle(1);
    pio = 6'h04;
    wait_state(UPDATE, "masked_lo1");
    wait_state(UPDATE, "masked_lo2");
    wait_state(UPDATE, "masked_lo3");
    idle(1);
    csr_read(ADDR_EDGE, 32'h01, "masked_edge");
    check("masked_irq", 32'(irq), 32'd0);
    csr_write(ADDR_MASK, 32'h01);
    check("unmask_irq", 32'(irq), 32'd1);
    csr_write(ADDR_EDGE, 32'h01);
    check("unmask_clear_irq", 32'(irq), 32'd0);
    csr_read(ADDR_STATE, 32'h04, "masked_state");

    // Set-vs-clear collision on bit 1.
    wait_state(UPDATE, "sync_collide");
    pio = 6'h06;
    wait_state(UPDATE, "collide_poll1");
    wait_state(UPDATE, "collide_poll2");
    wait_state(UPDATE, "collide_poll3");
    csr_write(ADDR_EDGE, 32'h02);
    csr_read(ADDR_EDGE, 32'h02, "collide_edge");
    csr_read(ADDR_STATE, 32'h06, "collide_state");
    csr_rw(ADDR_EDGE, 32'h02, 32'h02, "rw_preclear");
    csr_read(ADDR_EDGE, 32'h00, "rw_cleared");
    csr_read(ADDR_STATE, 32'h06, "hold_src");
    idle(3);
    check("rdata_hold", s_readdata, 32'h06);
    csr_write(ADDR_RSVD, 32'hFFFF_FFFF);
    csr_read(ADDR_RSVD, 32'h00, "rsvd_read");
    csr_read(ADDR_MASK, 32'h01, "mask_after_rsvd");

    // Reset in the SAMPLE state with live mask/edge/irq.
    csr_write(ADDR_MASK, 32'h02);
    pio = 6'h04;
    idle(14);
    check("pre_reset_irq", 32'(irq), 32'd1);
    wait_state(SAMPLE, "sync_sample");
    reset_n = 1'b0;
    #1;
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    check("midrst_irq", 32'(irq), 32'd0);
    check("midrst_rdata", s_readdata, 32'd0);
    check("midrst_sample", 32'(dut.sample_q), 32'd0);
    idle(1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    csr_read(ADDR_STATE, 32'h00, "midrst_csr0");
    csr_read(ADDR_MASK, 32'h00, "midrst_csr2");
    csr_read(ADDR_EDGE, 32'h00, "midrst_csr3");
    idle(12);
    csr_read(ADDR_STATE, 32'h04, "resume_state");
    csr_read(ADDR_EDGE, 32'h04, "resume_edge");
    check("resume_irq", 32'(irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
